// File: rtl/seq_div_fsm.sv
// seq_div_fsm: multi-cycle restoring divider (DIV/REM unit) with start/busy/done
// handshake, optional two's-complement operands and divide-by-zero reporting.
module seq_div_fsm #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] prem_r, prem_s;
    logic [WIDTH-1:0] shq_r, shq_s;
    logic [WIDTH-1:0] dvs_r, dvs_s;
    logic             q_neg_r, q_neg_s;
    logic             r_neg_r, r_neg_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             dbz_r, dbz_s;
    logic [WIDTH-1:0] quo_r, quo_s;
    logic [WIDTH-1:0] rmd_r, rmd_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] prem_step_s;
    logic [WIDTH-1:0] shq_step_s;

    // Next-state, one restoring step of the datapath, and output register loads.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        prem_s  = prem_r;
        shq_s   = shq_r;
        dvs_s   = dvs_r;
        q_neg_s = q_neg_r;
        r_neg_s = r_neg_r;
        dbz_s   = dbz_r;
        quo_s   = quo_r;
        rmd_s   = rmd_r;

        // The shifted partial remainder needs WIDTH+1 bits before the subtract.
        trial_s     = {prem_r, shq_r[WIDTH-1]} - {1'b0, dvs_r};
        prem_step_s = trial_s[WIDTH] ? {prem_r[WIDTH-2:0], shq_r[WIDTH-1]} : trial_s[WIDTH-1:0];
        shq_step_s  = {shq_r[WIDTH-2:0], ~trial_s[WIDTH]};

        case (state_r)
            IDLE: begin
                if (start) begin
                    q_neg_s = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_s = signed_mode & dividend[WIDTH-1];
                    dvs_s   = magnitude(divisor, signed_mode);
                    if (divisor == ZERO) begin
                        state_s = DONE;
                        quo_s   = {WIDTH{1'b1}};
                        rmd_s   = dividend;
                        dbz_s   = 1'b1;
                    end else begin
                        state_s = ITER;
                        cnt_s   = {CNT_W{1'b0}};
                        prem_s  = ZERO;
                        shq_s   = magnitude(dividend, signed_mode);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                prem_s = prem_step_s;
                shq_s  = shq_step_s;
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = DONE;
                    quo_s   = q_neg_r ? negate(shq_step_s) : shq_step_s;
                    rmd_s   = r_neg_r ? negate(prem_step_s) : prem_step_s;
                    dbz_s   = 1'b0;
                end else begin
                    state_s = ITER;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State, work and output registers; reset discards any operation in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            prem_r  <= ZERO;
            shq_r   <= ZERO;
            dvs_r   <= ZERO;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            quo_r   <= ZERO;
            rmd_r   <= ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            prem_r  <= prem_s;
            shq_r   <= shq_s;
            dvs_r   <= dvs_s;
            q_neg_r <= q_neg_s;
            r_neg_r <= r_neg_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            dbz_r   <= dbz_s;
            quo_r   <= quo_s;
            rmd_r   <= rmd_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quo_r;
    assign remainder   = rmd_r;
endmodule

// File: tb/tb_seq_div_fsm.sv
// tb_seq_div_fsm: scoreboard bench driving an 8-bit and a 32-bit divider with
// directed vectors; a monitor per instance checks results and latency at done.
module tb_seq_div_fsm;
    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    logic        start8, sm8, busy8, done8, dbz8;
    logic [7:0]  dd8, dv8, q8, r8;
    logic        start32, sm32, busy32, done32, dbz32;
    logic [31:0] dd32, dv32, q32, r32;

    seq_div_fsm #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .reset(reset), .start(start8), .signed_mode(sm8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .quotient(q8), .remainder(r8)
    );

    seq_div_fsm #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .reset(reset), .start(start32), .signed_mode(sm32),
        .dividend(dd32), .divisor(dv32), .busy(busy32), .done(done32),
        .div_by_zero(dbz32), .quotient(q32), .remainder(r32)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb32[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: results at done, outputs held otherwise.
    logic [7:0] hq8, hr8;
    logic       hd8;
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (reset) begin
            hq8 = 8'd0; hr8 = 8'd0; hd8 = 1'b0;
        end else if (done8) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb8.pop_front();
                check("w8_quotient", {24'd0, q8}, e.q);
                check("w8_remainder", {24'd0, r8}, e.r);
                check("w8_div_by_zero", {31'd0, dbz8}, {31'd0, e.dbz});
                check("w8_latency", 32'(cyc), 32'(e.cyc));
                check("w8_busy_in_done", {31'd0, busy8}, 32'd1);
            end
            hq8 = q8; hr8 = r8; hd8 = dbz8;
        end else begin
            check("w8_outputs_held", {15'd0, hd8, hq8, hr8}, {15'd0, dbz8, q8, r8});
        end
    end

    // Monitor for the 32-bit instance.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (!reset && done32) begin
            if (sb32.size() == 0) begin
                check("w32_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb32.pop_front();
                check("w32_quotient", q32, e.q);
                check("w32_remainder", r32, e.r);
                check("w32_div_by_zero", {31'd0, dbz32}, {31'd0, e.dbz});
                check("w32_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle(input bit w32);
        int guard = 0;
        @(negedge CLK);
        while ((w32 ? busy32 : busy8) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push8(input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = edbz;
        e.cyc = cyc + 1 + (edbz ? 0 : 8);
        sb8.push_back(e);
    endtask

    // Issue one request at an IDLE edge; operands are scrambled right after accept.
    task automatic issue(input bit w32, input logic sm, input logic [31:0] dd, input logic [31:0] dv,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        exp_t e;
        wait_idle(w32);
        e.q = eq; e.r = er; e.dbz = edbz;
        e.cyc = cyc + 1 + (edbz ? 0 : (w32 ? 32 : 8));
        if (w32) begin
            start32 = 1'b1; sm32 = sm; dd32 = dd; dv32 = dv;
            sb32.push_back(e);
        end else begin
            start8 = 1'b1; sm8 = sm; dd8 = dd[7:0]; dv8 = dv[7:0];
            sb8.push_back(e);
        end
        @(posedge CLK);
        #2;
        check("busy_after_accept", {31'd0, (w32 ? busy32 : busy8)}, 32'd1);
        @(negedge CLK);
        if (w32) begin
            start32 = 1'b0; sm32 = ~sm; dd32 = ~dd; dv32 = 32'd0;
        end else begin
            start8 = 1'b0; sm8 = ~sm; dd8 = ~dd[7:0]; dv8 = 8'd0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; dd8 = 8'd0; dv8 = 8'd0;
        start32 = 1'b0; sm32 = 1'b0; dd32 = 32'd0; dv32 = 32'd0;
        repeat (3) @(negedge CLK);
        check("reset_w8_outputs", {21'd0, busy8, done8, dbz8, q8}, 32'd0);
        check("reset_w8_remainder", {24'd0, r8}, 32'd0);
        check("reset_w32_flags", {29'd0, busy32, done32, dbz32}, 32'd0);
        check("reset_w32_quotient", q32, 32'd0);
        reset = 1'b0;

        // Unsigned basics and divide-by-zero.
        issue(1'b0, 1'b0, 32'd100, 32'd7, 32'h0E, 32'h02, 1'b0);
        issue(1'b0, 1'b0, 32'd255, 32'd0, 32'hFF, 32'hFF, 1'b1);
        issue(1'b0, 1'b0, 32'd9, 32'd3, 32'h03, 32'h00, 1'b0);

        // Signed: truncation toward zero, remainder follows dividend, MIN/-1 wraps.
        issue(1'b0, 1'b1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0);
        issue(1'b0, 1'b1, 32'h07, 32'hFE, 32'hFD, 32'h01, 1'b0);
        issue(1'b0, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0);
        issue(1'b0, 1'b1, 32'hF9, 32'h00, 32'hFF, 32'hF9, 1'b1);

        // start held high with operands changing every cycle: accepts 10 cycles apart.
        wait_idle(1'b0);
        sm8 = 1'b0;
        for (int k = 0; k < 21; k++) begin
            start8 = 1'b1;
            dd8 = 8'(200 - 7 * k);
            dv8 = 8'((k % 7) + 1);
            if (k == 0)  push8(32'd200, 32'd0, 1'b0);
            if (k == 10) push8(32'd32, 32'd2, 1'b0);
            if (k == 20) push8(32'd8, 32'd4, 1'b0);
            @(negedge CLK);
        end
        start8 = 1'b0;

        // Reset in the 4th ITER cycle of 200/3 drops the operation.
        wait_idle(1'b0);
        start8 = 1'b1; sm8 = 1'b0; dd8 = 8'd200; dv8 = 8'd3;
        @(negedge CLK);
        start8 = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("midop_reset_flags", {29'd0, busy8, done8, dbz8}, 32'd0);
        check("midop_reset_results", {16'd0, q8, r8}, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge CLK);
        issue(1'b0, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0);

        // 32-bit operands.
        issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);
        issue(1'b1, 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        issue(1'b1, 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);

        guard = 0;
        while ((sb8.size() != 0 || sb32.size() != 0) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge CLK);
        check("final_idle", {30'd0, busy8, busy32}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
